// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and
// the MEM-stage data access. Data wins ties, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
  parameter int                  WORD_LEN = 32,
  parameter int                  TIMEOUT  = 64,
  parameter logic [WORD_LEN-1:0] ERR_WORD = WORD_LEN'(32'hDEADBEEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [WORD_LEN-1:0] if_addr,
  output logic [WORD_LEN-1:0] if_rdata,
  output logic                if_valid,
  input  logic                d_rd,
  input  logic                d_wr,
  input  logic [WORD_LEN-1:0] d_addr,
  input  logic [WORD_LEN-1:0] d_wdata,
  output logic [WORD_LEN-1:0] d_rdata,
  output logic                d_valid,
  output logic                stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [WORD_LEN-1:0] mem_addr,
  output logic [WORD_LEN-1:0] mem_wdata,
  input  logic                mem_ack,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic {FETCH, DATA} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] wdog;

  // A requester holds its request until its valid pulse, so stall falls in that cycle.
  assign stall = (if_req & ~if_valid) | ((d_rd | d_wr) & ~d_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= FETCH;
      wdog      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE: begin
          wdog <= '0;
          // Data belongs to the older instruction, so it is served first.
          if (d_rd || d_wr) begin
            owner     <= DATA;
            mem_addr  <= d_addr;
            mem_we    <= d_wr;
            mem_wdata <= d_wdata;
            mem_req   <= 1'b1;
            state     <= BUSY;
          end else if (if_req) begin
            owner    <= FETCH;
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
            mem_req  <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RESP;
            if (owner == FETCH) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) d_rdata <= mem_rdata;
              d_valid <= 1'b1;
            end
          end else if (wdog == CNT_W'(TIMEOUT - 1)) begin
            // Memory never answered: complete the access with a poison word.
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= RESP;
            if (owner == FETCH) begin
              if_rdata <= ERR_WORD;
              if_valid <= 1'b1;
            end else begin
              d_rdata <= ERR_WORD;
              d_valid <= 1'b1;
            end
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        RESP: begin
          // The requester still holds the completed request here, so nothing is sampled.
          wdog  <= '0;
          state <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a behavioural memory
// and a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam logic [31:0] ERRW = 32'hDEADBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0;
  logic [W-1:0]  if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [W-1:0]  if_rdata, d_rdata, mem_addr, mem_wdata;
  logic          if_valid, d_valid, stall, mem_req, mem_we, err;
  logic          mem_ack = 1'b0;
  logic [W-1:0]  mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_LEN(W), .TIMEOUT(TO), .ERR_WORD(ERRW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;
  int lat_cfg = 0;
  bit resp_en = 1'b1;
  int pulse_at = -1;
  int wcnt = 0;

  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_d_rdata = '0;
  logic [31:0] exp_if_rdata = '0;
  logic        exp_err = 1'b0;

  function automatic logic [31:0] fill(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: acks lat_cfg cycles after mem_req rises, or on a forced pulse.
  initial begin
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (cyc == pulse_at) begin
        mem_ack = 1'b1;
      end else if (mem_req && resp_en) begin
        if (wcnt >= lat_cfg) begin
          mem_ack = 1'b1;
          wcnt = 0;
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : fill(mem_addr);
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    checks++;
    assert (!(if_valid && d_valid)) else begin
      failures++;
      $error("FAIL valid_overlap observed=%b%b expected=not both", if_valid, d_valid);
    end
    if (mem_req && !prev_req) req_rises++;
    prev_req = mem_req;
  endtask

  // kind: 0 fetch, 1 data read, 2 data write
  task automatic issue(input int kind, input logic [31:0] a, input logic [31:0] wd,
                       input int lat, input bit expect_to);
    int k;
    int reqc;
    logic done;
    logic [31:0] cap_addr, cap_wd;
    logic cap_we;
    lat_cfg = lat;
    resp_en = !expect_to;
    case (kind)
      0: begin if_req = 1'b1; if_addr = a; end
      1: begin d_rd = 1'b1; d_addr = a; end
      default: begin d_wr = 1'b1; d_addr = a; d_wdata = wd; end
    endcase
    k = 0; reqc = 0; done = 1'b0;
    cap_addr = '0; cap_wd = '0; cap_we = 1'b0;
    while (!done && k < 100) begin
      tick();
      k++;
      if (k == 1) begin
        chk("stall_busy", stall, 1'b1);
        chk("req_first", mem_req, 1'b1);
        cap_addr = mem_addr; cap_we = mem_we; cap_wd = mem_wdata;
      end
      if (mem_req) reqc++;
      if ((kind == 0 && if_valid) || (kind != 0 && d_valid)) done = 1'b1;
    end
    chk("done", done, 1'b1);
    chk("latency", k, expect_to ? TO + 1 : lat + 2);
    chk("req_cycles", reqc, expect_to ? TO : lat + 1);
    chk("mem_addr", cap_addr, a);
    chk("mem_we", cap_we, kind == 2);
    chk("stall_valid", stall, 1'b0);
    if (expect_to) exp_err = 1'b1;
    case (kind)
      0: begin
        exp_if_rdata = expect_to ? ERRW : ref_rd(a);
        chk("if_rdata", if_rdata, exp_if_rdata);
      end
      1: begin
        exp_d_rdata = expect_to ? ERRW : ref_rd(a);
        chk("d_rdata", d_rdata, exp_d_rdata);
      end
      default: begin
        chk("mem_wdata", cap_wd, wd);
        if (expect_to) exp_d_rdata = ERRW;
        else ref_mem[a] = wd;
        chk("d_rdata_wr", d_rdata, exp_d_rdata);
      end
    endcase
    chk("err", err, exp_err);
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    tick();
    chk("stall_after", stall, 1'b0);
    chk("idle_after", mem_req, 1'b0);
  endtask

  initial begin
    int k;
    int kind;
    int lat;
    int r0;
    logic [31:0] a;
    logic [31:0] wd;

    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_d_valid", d_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_stall", stall, 1'b0);
    rst = 1'b0;
    tick();

    mem_arr[32'h10] = 32'h20080005;  ref_mem[32'h10] = 32'h20080005;
    mem_arr[32'h100] = 32'h0000ABCD; ref_mem[32'h100] = 32'h0000ABCD;
    mem_arr[32'h14] = 32'h11112222;  ref_mem[32'h14] = 32'h11112222;

    // Single fetch, ack one cycle after mem_req.
    issue(0, 32'h10, 32'h0, 1, 1'b0);

    // Simultaneous fetch and data read: data first.
    lat_cfg = 1; resp_en = 1'b1;
    if_req = 1'b1; if_addr = 32'h14; d_rd = 1'b1; d_addr = 32'h100;
    k = 0;
    while (!d_valid && k < 50) begin
      tick(); k++;
      if (k == 1) chk("sim_first_addr", mem_addr, 32'h100);
    end
    chk("sim_d_valid", d_valid, 1'b1);
    chk("sim_d_rdata", d_rdata, 32'h0000ABCD);
    chk("sim_if_wait", if_valid, 1'b0);
    exp_d_rdata = 32'h0000ABCD;
    d_rd = 1'b0;
    k = 0;
    while (!if_valid && k < 50) begin
      tick(); k++;
      if (k == 1) chk("sim_stall_fetch", stall, 1'b1);
      if (k == 2) chk("sim_second_addr", mem_addr, 32'h14);
    end
    chk("sim_if_valid", if_valid, 1'b1);
    chk("sim_if_rdata", if_rdata, 32'h11112222);
    exp_if_rdata = 32'h11112222;
    if_req = 1'b0;
    tick();

    // Store with zero-latency ack, then read it back.
    issue(2, 32'h200, 32'hCAFEF00D, 0, 1'b0);
    issue(1, 32'h200, 32'h0, 2, 1'b0);

    // Randomized traffic over a small address window.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
      wd = $urandom;
      lat = $urandom_range(0, 3);
      issue(kind, a, wd, lat, 1'b0);
    end

    // Back-to-back fetches with if_req held.
    lat_cfg = 0; resp_en = 1'b1;
    r0 = req_rises;
    if_req = 1'b1; if_addr = 32'h0;
    k = 0;
    while (!if_valid && k < 50) begin tick(); k++; end
    chk("b2b_lat0", k, 2);
    chk("b2b_rdata0", if_rdata, ref_rd(32'h0));
    if_addr = 32'h4;
    tick();
    chk("b2b_gap_req", mem_req, 1'b0);
    chk("b2b_gap_valid", if_valid, 1'b0);
    tick();
    chk("b2b_req1", mem_req, 1'b1);
    chk("b2b_addr1", mem_addr, 32'h4);
    tick();
    chk("b2b_valid1", if_valid, 1'b1);
    chk("b2b_rdata1", if_rdata, ref_rd(32'h4));
    exp_if_rdata = ref_rd(32'h4);
    if_req = 1'b0;
    tick();
    chk("b2b_rises", req_rises - r0, 2);

    // Watchdog abort, then err stays set through a good access.
    issue(1, 32'h300, 32'h0, 0, 1'b1);
    issue(0, 32'h10, 32'h0, 0, 1'b0);

    // Asynchronous reset in the middle of a fetch.
    resp_en = 1'b0; lat_cfg = 0;
    if_req = 1'b1; if_addr = 32'h20;
    tick(); tick();
    chk("rb_busy", mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rb_req_drop", mem_req, 1'b0);
    chk("rb_err_clr", err, 1'b0);
    chk("rb_if_rdata", if_rdata, 32'h0);
    chk("rb_d_rdata", d_rdata, 32'h0);
    exp_err = 1'b0; exp_d_rdata = '0; exp_if_rdata = '0;
    if_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    pulse_at = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rb_no_if_valid", if_valid, 1'b0);
      chk("rb_no_d_valid", d_valid, 1'b0);
      chk("rb_no_req", mem_req, 1'b0);
    end
    issue(0, 32'h24, 32'h0, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
